fwd_hazard_unit: RTL and testbench

- Producer end of the ALU operand-forwarding interface.
- Owns the two post-EX history stages, EX/MEM ("buf2") and MEM/WB ("buf3"). Each stage holds the destination register, write-back flag, memory-read flag, ALU result and captured load data.
- Drives the forwarding bundle (wb1/wb2, reg2_buf2/reg2_buf3, result_prev1/result_prev2, load-case data/flag) that the ALU consumes.
- Detects load-use hazards and inserts exactly one bubble per offending load.

---
 rtl/fwd_hazard_unit_pkg.sv | 30 +++
 rtl/fwd_stage_reg.sv | 28 ++
 rtl/fwd_hazard_unit.sv | 128 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: datapath widths, FSM state
// encoding and the layout of one post-EX history stage.
package fwd_hazard_unit_pkg;

    localparam int N     = 16;
    localparam int REG_W = 3;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } fsm_state_t;

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             wb;
        logic             mem_read;
        logic [N-1:0]     result;
        logic [N-1:0]     load_data;
    } stage_t;

    // An ID operand only depends on a register when the instruction actually reads it
    function automatic logic operand_match(input logic             used,
                                           input logic [REG_W-1:0] id_reg,
                                           input logic [REG_W-1:0] stage_reg);
        return used && (id_reg == stage_reg);
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One post-EX history stage: squashes the control flags of bubbles and
// optionally captures memory read data instead of the incoming load_data.
module fwd_stage_reg
    import fwd_hazard_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  stage_t       d,
    input  logic         kill,
    input  logic         capture,
    input  logic [N-1:0] capture_data,
    output stage_t       q
);

    // dst/result travel even for bubbles; only wb/mem_read carry meaning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q.dst       <= d.dst;
            q.result    <= d.result;
            q.wb        <= d.wb & ~kill;
            q.mem_read  <= d.mem_read & ~kill;
            q.load_data <= capture ? capture_data : d.load_data;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding producer: owns EX/MEM (buf2) and MEM/WB (buf3), detects load-use
// hazards and inserts one bubble per load. Optional counters: FWD_STATS_EN.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_wb,
    input  logic             ex_mem_read,
    input  logic [N-1:0]     ex_result,
    input  logic [N-1:0]     mem_rdata,
    input  logic [REG_W-1:0] id_src,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_src_used,
    input  logic             id_dst_used,
    input  logic             flush,
    output logic             stall,
    output logic             wb1,
    output logic             wb2,
    output logic [REG_W-1:0] reg2_buf2,
    output logic [REG_W-1:0] reg2_buf3,
    output logic [N-1:0]     result_prev1,
    output logic [N-1:0]     result_prev2,
    output logic             mem_read_load_case,
    output logic [N-1:0]     memory_data_output_load_case
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]      stall_count,
    output logic [15:0]      fwd_count
`endif
);

    fsm_state_t state;
    logic       hazard;
    logic       ex_kill;
    stage_t     buf2_d;
    stage_t     buf2_q;
    stage_t     buf3_d;
    stage_t     buf3_q;

    assign hazard = ex_valid & ex_mem_read & ex_wb & ~flush &
                    (operand_match(id_src_used, id_src, ex_dst) |
                     operand_match(id_dst_used, id_dst, ex_dst));

    // Gating with rst_n lets stall drop the moment reset asserts, not at the next edge
    assign stall   = rst_n & (state == IDLE) & hazard;
    assign ex_kill = ~ex_valid | flush | stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= hazard ? STALL : IDLE;
                STALL:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // buf3 inherits buf2 wholesale; its load_data only moves when buf2 holds a load
    always_comb begin
        buf2_d           = '0;
        buf2_d.dst       = ex_dst;
        buf2_d.wb        = ex_wb;
        buf2_d.mem_read  = ex_mem_read;
        buf2_d.result    = ex_result;
        buf3_d           = buf2_q;
        buf3_d.load_data = buf3_q.load_data;
    end

    fwd_stage_reg u_buf2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .d            (buf2_d),
        .kill         (ex_kill),
        .capture      (1'b0),
        .capture_data (mem_rdata),
        .q            (buf2_q)
    );

    fwd_stage_reg u_buf3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .d            (buf3_d),
        .kill         (1'b0),
        .capture      (buf2_q.mem_read),
        .capture_data (mem_rdata),
        .q            (buf3_q)
    );

    assign wb1                          = buf2_q.wb;
    assign wb2                          = buf3_q.wb;
    assign reg2_buf2                    = buf2_q.dst;
    assign reg2_buf3                    = buf3_q.dst;
    assign result_prev1                 = buf2_q.result;
    assign result_prev2                 = buf3_q.result;
    assign mem_read_load_case           = buf3_q.mem_read;
    assign memory_data_output_load_case = buf3_q.load_data;

`ifdef FWD_STATS_EN
    logic fwd_hit;

    assign fwd_hit =
        (buf2_q.wb & (operand_match(id_src_used, id_src, buf2_q.dst) |
                      operand_match(id_dst_used, id_dst, buf2_q.dst))) |
        (buf3_q.wb & (operand_match(id_src_used, id_src, buf3_q.dst) |
                      operand_match(id_dst_used, id_dst, buf3_q.dst)));

    // Both counters saturate so long runs never wrap back to small values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall && (stall_count != STAT_MAX)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (fwd_hit && (fwd_count != STAT_MAX)) begin
                fwd_count <= fwd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, hand-written
// async-reset sequence and randomized traffic against a behavioural model.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [2:0]  ex_dst;
    logic        ex_wb;
    logic        ex_mem_read;
    logic [15:0] ex_result;
    logic [15:0] mem_rdata;
    logic [2:0]  id_src;
    logic [2:0]  id_dst;
    logic        id_src_used;
    logic        id_dst_used;
    logic        flush;
    logic        stall;
    logic        wb1;
    logic        wb2;
    logic [2:0]  reg2_buf2;
    logic [2:0]  reg2_buf3;
    logic [15:0] result_prev1;
    logic [15:0] result_prev2;
    logic        mem_read_load_case;
    logic [15:0] memory_data_output_load_case;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .ex_valid                     (ex_valid),
        .ex_dst                       (ex_dst),
        .ex_wb                        (ex_wb),
        .ex_mem_read                  (ex_mem_read),
        .ex_result                    (ex_result),
        .mem_rdata                    (mem_rdata),
        .id_src                       (id_src),
        .id_dst                       (id_dst),
        .id_src_used                  (id_src_used),
        .id_dst_used                  (id_dst_used),
        .flush                        (flush),
        .stall                        (stall),
        .wb1                          (wb1),
        .wb2                          (wb2),
        .reg2_buf2                    (reg2_buf2),
        .reg2_buf3                    (reg2_buf3),
        .result_prev1                 (result_prev1),
        .result_prev2                 (result_prev2),
        .mem_read_load_case           (mem_read_load_case),
        .memory_data_output_load_case (memory_data_output_load_case)
    );

    typedef struct {
        logic        ex_valid;
        logic [2:0]  ex_dst;
        logic        ex_wb;
        logic        ex_mem_read;
        logic [15:0] ex_result;
        logic [15:0] mem_rdata;
        logic [2:0]  id_src;
        logic [2:0]  id_dst;
        logic        src_used;
        logic        dst_used;
        logic        flush;
        logic        exp_stall;
        logic        exp_wb1;
        logic [2:0]  exp_r2b2;
        logic [15:0] exp_rp1;
        logic        exp_wb2;
        logic [2:0]  exp_r2b3;
        logic [15:0] exp_rp2;
        logic        exp_mrlc;
        logic [15:0] exp_md;
    } vec_t;

    typedef struct {
        logic [2:0]  dst;
        logic        wb;
        logic        mr;
        logic [15:0] res;
        logic [15:0] ld;
    } mstage_t;

    vec_t    vecs[12];
    mstage_t m_b2;
    mstage_t m_b3;
    bit      m_stalled;

    // Reference: a load stalls once unless the previous cycle already stalled for it
    function automatic bit model_stall();
        bit hz;
        hz = ex_valid && ex_mem_read && ex_wb && !flush &&
             ((id_src_used && id_src == ex_dst) || (id_dst_used && id_dst == ex_dst));
        return !m_stalled && hz;
    endfunction

    task automatic model_reset();
        m_b2      = '{3'd0, 1'b0, 1'b0, 16'h0, 16'h0};
        m_b3      = '{3'd0, 1'b0, 1'b0, 16'h0, 16'h0};
        m_stalled = 1'b0;
    endtask

    task automatic model_edge();
        bit st;
        bit ok;
        st   = model_stall();
        ok   = ex_valid && !flush && !st;
        m_b3 = '{m_b2.dst, m_b2.wb, m_b2.mr, m_b2.res, m_b2.mr ? mem_rdata : m_b3.ld};
        m_b2 = '{ex_dst, ex_wb && ok, ex_mem_read && ok, ex_result, 16'h0};
        m_stalled = st;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic e_wb1, input logic [2:0] e_r2b2,
                                input logic [15:0] e_rp1, input logic e_wb2,
                                input logic [2:0] e_r2b3, input logic [15:0] e_rp2,
                                input logic e_mrlc, input logic [15:0] e_md);
        check({tag, ".wb1"}, 32'(wb1), 32'(e_wb1));
        check({tag, ".reg2_buf2"}, 32'(reg2_buf2), 32'(e_r2b2));
        check({tag, ".result_prev1"}, 32'(result_prev1), 32'(e_rp1));
        check({tag, ".wb2"}, 32'(wb2), 32'(e_wb2));
        check({tag, ".reg2_buf3"}, 32'(reg2_buf3), 32'(e_r2b3));
        check({tag, ".result_prev2"}, 32'(result_prev2), 32'(e_rp2));
        check({tag, ".mem_read_load_case"}, 32'(mem_read_load_case), 32'(e_mrlc));
        check({tag, ".load_data"}, 32'(memory_data_output_load_case), 32'(e_md));
    endtask

    task automatic check_model(input string tag);
        check_output(tag, m_b2.wb, m_b2.dst, m_b2.res, m_b3.wb, m_b3.dst, m_b3.res,
                     m_b3.mr, m_b3.ld);
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        ex_valid    = v.ex_valid;
        ex_dst      = v.ex_dst;
        ex_wb       = v.ex_wb;
        ex_mem_read = v.ex_mem_read;
        ex_result   = v.ex_result;
        mem_rdata   = v.mem_rdata;
        id_src      = v.id_src;
        id_dst      = v.id_dst;
        id_src_used = v.src_used;
        id_dst_used = v.dst_used;
        flush       = v.flush;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_random();
        @(negedge clk);
        ex_valid    = ($urandom_range(0, 7) != 0);
        ex_dst      = 3'($urandom_range(0, 3));
        ex_wb       = ($urandom_range(0, 3) != 0);
        ex_mem_read = $urandom_range(0, 1) == 1;
        ex_result   = 16'($urandom);
        mem_rdata   = 16'($urandom);
        id_src      = 3'($urandom_range(0, 3));
        id_dst      = 3'($urandom_range(0, 3));
        id_src_used = $urandom_range(0, 1) == 1;
        id_dst_used = $urandom_range(0, 1) == 1;
        flush       = ($urandom_range(0, 7) == 0);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd3, 1'b1, 1'b0, 16'h00AA, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 3'd3, 16'h00AA, 1'b1, 3'd0, 16'h1234, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 3'd5, 1'b1, 1'b0, 16'h00BB, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 3'd5, 16'h00BB, 1'b1, 3'd3, 16'h00AA, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 3'd2, 1'b1, 1'b1, 16'h0040, 16'h0000, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0,
                     1'b1, 1'b0, 3'd2, 16'h0040, 1'b1, 3'd5, 16'h00BB, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 3'd2, 1'b1, 1'b1, 16'h0040, 16'h0000, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0,
                     1'b0, 1'b1, 3'd2, 16'h0040, 1'b0, 3'd2, 16'h0040, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 3'd4, 1'b1, 1'b0, 16'h1111, 16'hBEEF, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 3'd4, 16'h1111, 1'b1, 3'd2, 16'h0040, 1'b1, 16'hBEEF};
        vecs[5]  = '{1'b1, 3'd6, 1'b1, 1'b1, 16'h0050, 16'h0000, 3'd6, 3'd6, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 3'd6, 16'h0050, 1'b1, 3'd4, 16'h1111, 1'b0, 16'hBEEF};
        vecs[6]  = '{1'b1, 3'd1, 1'b1, 1'b1, 16'h0060, 16'hCAFE, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1,
                     1'b0, 1'b0, 3'd1, 16'h0060, 1'b1, 3'd6, 16'h0050, 1'b1, 16'hCAFE};
        vecs[7]  = '{1'b1, 3'd7, 1'b1, 1'b1, 16'h0070, 16'h0000, 3'd0, 3'd7, 1'b0, 1'b1, 1'b0,
                     1'b1, 1'b0, 3'd7, 16'h0070, 1'b0, 3'd1, 16'h0060, 1'b0, 16'hCAFE};
        vecs[8]  = '{1'b1, 3'd7, 1'b1, 1'b1, 16'h0070, 16'h0000, 3'd0, 3'd7, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b1, 3'd7, 16'h0070, 1'b0, 3'd7, 16'h0070, 1'b0, 16'hCAFE};
        vecs[9]  = '{1'b1, 3'd0, 1'b1, 1'b1, 16'h0080, 16'h1357, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0,
                     1'b1, 1'b0, 3'd0, 16'h0080, 1'b1, 3'd7, 16'h0070, 1'b1, 16'h1357};
        vecs[10] = '{1'b1, 3'd0, 1'b1, 1'b1, 16'h0080, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0,
                     1'b0, 1'b1, 3'd0, 16'h0080, 1'b0, 3'd0, 16'h0080, 1'b0, 16'h1357};
        vecs[11] = '{1'b0, 3'd3, 1'b1, 1'b0, 16'h9999, 16'h2468, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 3'd3, 16'h9999, 1'b1, 3'd0, 16'h0080, 1'b1, 16'h2468};

        // Reset with a live write and a hazard pattern on the inputs
        rst_n       = 1'b0;
        ex_valid    = 1'b1;
        ex_dst      = 3'd0;
        ex_wb       = 1'b1;
        ex_mem_read = 1'b1;
        ex_result   = 16'h1234;
        mem_rdata   = 16'h0000;
        id_src      = 3'd0;
        id_dst      = 3'd0;
        id_src_used = 1'b1;
        id_dst_used = 1'b0;
        flush       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.stall", 32'(stall), 32'd0);
        check_output("reset", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);

        ex_mem_read = 1'b0;
        id_src_used = 1'b0;
        rst_n       = 1'b1;
        edge_step();
        check("release.wb1", 32'(wb1), 32'd1);
        check("release.result_prev1", 32'(result_prev1), 32'h1234);

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i]);
            check($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            edge_step();
            check_output($sformatf("vec%0d", i), vecs[i].exp_wb1, vecs[i].exp_r2b2,
                         vecs[i].exp_rp1, vecs[i].exp_wb2, vecs[i].exp_r2b3,
                         vecs[i].exp_rp2, vecs[i].exp_mrlc, vecs[i].exp_md);
        end

        for (int i = 0; i < 400; i++) begin
            drive_random();
            check($sformatf("rand%0d.stall", i), 32'(stall), 32'(model_stall()));
            edge_step();
            check_model($sformatf("rand%0d", i));
        end

        // Neutral cycle so the FSM is known to be idle before the reset test
        @(negedge clk);
        ex_valid = 1'b0;
        flush    = 1'b0;
        #1;
        edge_step();
        check_model("neutral");

        @(negedge clk);
        ex_valid    = 1'b1;
        ex_dst      = 3'd4;
        ex_wb       = 1'b1;
        ex_mem_read = 1'b1;
        ex_result   = 16'h0ABC;
        id_src      = 3'd4;
        id_src_used = 1'b1;
        id_dst_used = 1'b0;
        #1;
        check("midreset.stall_before", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset.stall_async", 32'(stall), 32'd0);
        check_output("midreset", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postreset.stall_idle", 32'(stall), 32'd1);
        edge_step();
        check_model("postreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
